// File: rtl/cpu_pkg.sv
// Shared types and default constants for the 16-bit RISC pipeline.
// The defaults for PC width, reset PC, IVT location and bubble word live here.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        VEC_LO = 2'd1,
        VEC_HI = 2'd2
    } fetch_state_t;

    localparam int          DEFAULT_PC_W     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0020;
    localparam logic [31:0] DEFAULT_IVT_ADDR = 32'h0000_0000;
    localparam logic [15:0] DEFAULT_NOP_WORD = 16'h0000;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and fills IF/ID.
// On an interrupt it saves the return PC and loads a new PC from a two-word IVT entry.
//
// state  | meaning
// RUN    | normal fetch / stall / inject / branch handling
// VEC_LO | reading low half of IVT entry at IVT_ADDR
// VEC_HI | reading high half at IVT_ADDR+1, then jump to the vector
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
    parameter logic [PC_W-1:0] IVT_ADDR = PC_W'(DEFAULT_IVT_ADDR),
    parameter logic [15:0]     NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            inject_valid,
    input  logic [15:0]     inject_instr,
    input  logic            int_raise,
    output logic [15:0]     instr_o,
    output logic [PC_W-1:0] pc_next_o,
    output logic            valid_o,
    output logic [PC_W-1:0] epc_o,
    output logic            busy_o
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     vec_lo_q, vec_lo_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_next_q, pc_next_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [31:0]     vec_full;

    assign vec_full = {imem_data, vec_lo_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            vec_lo_q  <= '0;
            instr_q   <= NOP_WORD;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
            epc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            vec_lo_q  <= vec_lo_d;
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        vec_lo_d  = vec_lo_q;
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        epc_d     = epc_q;
        unique case (state_q)
            RUN: begin
                if (int_raise) begin
                    // A branch resolving in the same cycle becomes the return point.
                    epc_d   = branch_taken ? branch_target : pc_q;
                    pc_d    = IVT_ADDR;
                    state_d = VEC_LO;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (branch_taken) begin
                    pc_d    = branch_target;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (inject_valid) begin
                    instr_d   = inject_instr;
                    pc_next_d = pc_q;
                    valid_d   = 1'b1;
                end else begin
                    instr_d   = imem_data;
                    pc_next_d = pc_q + PC_W'(1);
                    valid_d   = 1'b1;
                    pc_d      = pc_q + PC_W'(1);
                end
            end
            VEC_LO: begin
                vec_lo_d = imem_data;
                pc_d     = IVT_ADDR + PC_W'(1);
                instr_d  = NOP_WORD;
                valid_d  = 1'b0;
                state_d  = VEC_HI;
            end
            VEC_HI: begin
                pc_d    = PC_W'(vec_full);
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign instr_o   = instr_q;
    assign pc_next_o = pc_next_q;
    assign valid_o   = valid_q;
    assign epc_o     = epc_q;
    assign busy_o    = (state_q != RUN);

    // The handler must not pulse again while a vector fetch is in flight.
    a_no_raise_when_busy: assert property (
        @(posedge clk) disable iff (!reset_n) !(int_raise && busy_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver feeds directed and random stimulus
// through a reference model; a monitor compares the DUT after every rising edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall, branch_taken, inject_valid, int_raise;
    logic [31:0] branch_target;
    logic [15:0] inject_instr;
    logic [15:0] instr_o;
    logic [31:0] pc_next_o, epc_o;
    logic        valid_o, busy_o;

    logic [15:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] instr;
        logic [31:0] pcn;
        logic        valid;
        logic [31:0] epc;
        logic        busy;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [31:0] m_pc, m_pcn, m_epc;
    logic [15:0] m_instr, m_vlo;
    logic        m_valid;
    int          m_vec_left;

    fetch_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .inject_valid (inject_valid),
        .inject_instr (inject_instr),
        .int_raise    (int_raise),
        .instr_o      (instr_o),
        .pc_next_o    (pc_next_o),
        .valid_o      (valid_o),
        .epc_o        (epc_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd(input logic [31:0] a);
        logic [9:0] idx;
        idx = a[9:0];
        return mem[idx];
    endfunction

    assign imem_data = rd(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h20; m_pcn = '0; m_epc = '0; m_instr = 16'h0000;
        m_vlo = '0; m_valid = 1'b0; m_vec_left = 0;
    endtask

    // One clock of behaviour: vector fetch takes two reads, then normal fetch resumes.
    task automatic model_step(input logic raise, input logic br, input logic [31:0] tgt,
                              input logic stl, input logic inj, input logic [15:0] iw);
        logic [15:0] data;
        exp_t e;
        data = rd(m_pc);
        if (m_vec_left == 2) begin
            m_vlo = data; m_pc = 32'h1; m_instr = 16'h0; m_valid = 0; m_vec_left = 1;
        end else if (m_vec_left == 1) begin
            m_pc = {data, m_vlo}; m_instr = 16'h0; m_valid = 0; m_vec_left = 0;
        end else if (raise) begin
            m_epc = br ? tgt : m_pc;
            m_pc = 32'h0; m_instr = 16'h0; m_valid = 0; m_vec_left = 2;
        end else if (br) begin
            m_pc = tgt; m_instr = 16'h0; m_valid = 0;
        end else if (stl) begin
            // everything holds
        end else if (inj) begin
            m_instr = iw; m_pcn = m_pc; m_valid = 1;
        end else begin
            m_instr = data; m_pc = m_pc + 1; m_pcn = m_pc; m_valid = 1;
        end
        e.instr = m_instr; e.pcn = m_pcn; e.valid = m_valid;
        e.epc = m_epc; e.busy = (m_vec_left != 0); e.addr = m_pc;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge: drive inputs, predict, advance one cycle.
    task automatic step(input logic raise, input logic br, input logic [31:0] tgt,
                        input logic stl, input logic inj, input logic [15:0] iw);
        int_raise = raise; branch_taken = br; branch_target = tgt;
        stall = stl; inject_valid = inj; inject_instr = iw;
        model_step(raise, br, tgt, stl, inj, iw);
        @(negedge clk);
    endtask

    task automatic plain();
        step(0, 0, 32'h0, 0, 0, 16'h0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_instr"}, {16'h0, instr_o}, 32'h0);
        chk({tag, "_valid"}, {31'h0, valid_o}, 32'h0);
        chk({tag, "_busy"},  {31'h0, busy_o}, 32'h0);
        chk({tag, "_addr"},  imem_addr, 32'h20);
        chk({tag, "_epc"},   epc_o, 32'h0);
        chk({tag, "_pcn"},   pc_next_o, 32'h0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instr",   {16'h0, instr_o}, {16'h0, e.instr});
            chk("pc_next", pc_next_o, e.pcn);
            chk("valid",   {31'h0, valid_o}, {31'h0, e.valid});
            chk("epc",     epc_o, e.epc);
            chk("busy",    {31'h0, busy_o}, {31'h0, e.busy});
            chk("addr",    imem_addr, e.addr);
        end
    end

    initial begin
        logic r, b, s, inj;
        reset_n = 1'b0;
        int_raise = 0; branch_taken = 0; branch_target = '0;
        stall = 0; inject_valid = 0; inject_instr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0100; mem[1] = 16'h0000;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst_init");
        reset_n = 1'b1;

        // sequential fetch from 0x20, then branch to 0x25 and stall there
        plain(); plain(); plain();
        step(0, 1, 32'h25, 0, 0, 16'h0);
        step(0, 0, 32'h0, 1, 0, 16'h0);
        step(0, 0, 32'h0, 1, 0, 16'h0);
        plain();
        // branch while stalled: branch flushes
        step(0, 1, 32'h30, 1, 0, 16'h0);
        step(0, 0, 32'h0, 0, 1, 16'h07F8);
        step(0, 0, 32'h0, 0, 1, 16'hF480);
        step(0, 0, 32'h0, 0, 1, 16'h1234);
        plain();
        // interrupt at pc 0x40
        step(0, 1, 32'h40, 0, 0, 16'h0);
        step(1, 0, 32'h0, 0, 0, 16'h0);
        plain(); plain(); plain(); plain();
        // interrupt racing a branch; branch in VEC_LO ignored
        step(1, 1, 32'h80, 0, 0, 16'h0);
        step(0, 1, 32'h200, 1, 1, 16'hAAAA);
        plain(); plain(); plain();
        // interrupt with stall
        step(1, 0, 32'h0, 1, 0, 16'h0);
        plain(); plain(); plain();
        // vector to all-ones: PC wraps to zero
        mem[0] = 16'hFFFF; mem[1] = 16'hFFFF;
        step(1, 0, 32'h0, 0, 0, 16'h0);
        plain(); plain(); plain(); plain(); plain();

        // randomized traffic
        mem[0] = 16'($urandom_range(32, 1000)); mem[1] = 16'h0000;
        for (int i = 0; i < 2000; i++) begin
            r   = (m_vec_left == 0) && ($urandom_range(0, 15) == 0);
            b   = ($urandom_range(0, 7) == 0);
            s   = ($urandom_range(0, 4) == 0);
            inj = ($urandom_range(0, 5) == 0);
            step(r, b, 32'($urandom_range(0, 1023)), s, inj, 16'($urandom));
        end

        // reset in the middle of a vector fetch
        step(1, 0, 32'h0, 0, 0, 16'h0);
        reset_n = 1'b0;
        int_raise = 0; branch_taken = 0; stall = 0; inject_valid = 0;
        #1;
        check_reset_values("rst_vec");
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        plain(); plain();
        @(negedge clk);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
